// File: rtl/multibyte_uart_tx_cfg.sv
// multibyte_uart_tx_cfg
//   Multi-byte UART transmitter. Sends 1..NUMBER_OF_ELEMENTS elements from a
//   packed buffer as back-to-back UART frames. Divisor, parity, stop-bit count
//   and inter-frame gap are captured per message. An abort request takes effect
//   at the end of the frame in flight.
//
// Optional feature macro: UART_TX_CRC8_TRAILER_EN
//   When defined (ELEMENT_WIDTH must be 8), a CRC-8 (poly 0x07, init 0x00,
//   MSB-first) over the sent elements is appended as one extra frame, preceded
//   by the normal gap. No trailer is sent on abort.
//
// Ports
//   clk              system clock
//   rst              synchronous active-high reset
//   tx_en            start request, accepted only while tx_ready=1
//   tx_data          element buffer, element i sent i-th, stable while busy
//   tx_data_length   element count (0 ignored, clamped to NUMBER_OF_ELEMENTS)
//   delay_between_tx idle-high clocks between frames
//   baud_divisor     clocks per bit (0 treated as 1)
//   parity_mode      00 none, 01 even, 10 odd, 11 none
//   two_stop_bits    0: one stop bit, 1: two stop bits
//   tx_abort         stop after the current frame
//   tx_line          serial output, idle high
//   tx_ready         idle, can accept tx_en
//   tx_done          1-cycle pulse at end of message
//   tx_aborted       valid with tx_done: message was cut short
module multibyte_uart_tx_cfg #(
  parameter int ELEMENT_WIDTH      = 8,
  parameter int NUMBER_OF_ELEMENTS = 256,
  parameter int DELAY_WIDTH        = 32,
  parameter int DIVISOR_WIDTH      = 16
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              tx_en,
  input  logic [NUMBER_OF_ELEMENTS-1:0][ELEMENT_WIDTH-1:0]  tx_data,
  input  logic [$clog2(NUMBER_OF_ELEMENTS):0]               tx_data_length,
  input  logic [DELAY_WIDTH-1:0]                            delay_between_tx,
  input  logic [DIVISOR_WIDTH-1:0]                          baud_divisor,
  input  logic [1:0]                                        parity_mode,
  input  logic                                              two_stop_bits,
  input  logic                                              tx_abort,
  output logic                                              tx_line,
  output logic                                              tx_ready,
  output logic                                              tx_done,
  output logic                                              tx_aborted
);

  localparam int TRANSFER_COUNTER_WIDTH = $clog2(NUMBER_OF_ELEMENTS);
  localparam int LEN_W = TRANSFER_COUNTER_WIDTH + 1;
  localparam int BCW   = $clog2(ELEMENT_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  state_t                     r_state;
  logic                       r_line;
  logic                       r_ready;
  logic                       r_done;
  logic                       r_aborted;
  logic                       r_abort;
  logic [LEN_W-1:0]           r_len;
  logic [LEN_W-1:0]           r_idx;
  logic [DELAY_WIDTH-1:0]     r_delay;
  logic [DELAY_WIDTH-1:0]     r_gap_cnt;
  logic [DIVISOR_WIDTH-1:0]   r_div;
  logic [DIVISOR_WIDTH-1:0]   r_baud_cnt;
  logic [1:0]                 r_par_mode;
  logic                       r_two_stop;
  logic                       r_stop_cnt;
  logic [BCW-1:0]             r_bit_cnt;
  logic [ELEMENT_WIDTH-1:0]   r_shift;
  logic                       r_par_bit;

  logic                       w_bit_end;
  logic                       w_last;
  logic                       w_par_en;
  logic                       w_abort_now;
  logic                       w_more;
  logic [ELEMENT_WIDTH-1:0]   w_elem;

`ifdef UART_TX_CRC8_TRAILER_EN
  logic [ELEMENT_WIDTH-1:0]   r_crc;
  logic                       r_crc_frame;

  function automatic logic [ELEMENT_WIDTH-1:0] crc8_step(
    input logic [ELEMENT_WIDTH-1:0] c,
    input logic [ELEMENT_WIDTH-1:0] d
  );
    logic [ELEMENT_WIDTH-1:0] x;
    x = c ^ d;
    for (int unsigned i = 0; i < ELEMENT_WIDTH; i++) begin
      x = x[ELEMENT_WIDTH-1] ? ((x << 1) ^ ELEMENT_WIDTH'(8'h07)) : (x << 1);
    end
    return x;
  endfunction

  assign w_elem = r_crc_frame ? r_crc : tx_data[r_idx[TRANSFER_COUNTER_WIDTH-1:0]];
  assign w_more = !r_crc_frame;
`else
  assign w_elem = tx_data[r_idx[TRANSFER_COUNTER_WIDTH-1:0]];
  assign w_more = !w_last;
`endif

  assign w_bit_end   = (r_baud_cnt == r_div - DIVISOR_WIDTH'(1));
  assign w_last      = (r_idx == r_len - LEN_W'(1));
  assign w_par_en    = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
  assign w_abort_now = r_abort | tx_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_line     <= 1'b1;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_abort    <= 1'b0;
      r_len      <= '0;
      r_idx      <= '0;
      r_delay    <= '0;
      r_gap_cnt  <= '0;
      r_div      <= DIVISOR_WIDTH'(1);
      r_baud_cnt <= '0;
      r_par_mode <= '0;
      r_two_stop <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
`ifdef UART_TX_CRC8_TRAILER_EN
      r_crc       <= '0;
      r_crc_frame <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if ((r_state != S_IDLE) && tx_abort) r_abort <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          r_line  <= 1'b1;
          r_abort <= 1'b0;
          if (r_ready && tx_en && (tx_data_length != '0)) begin
            r_len      <= (tx_data_length > LEN_W'(NUMBER_OF_ELEMENTS)) ?
                          LEN_W'(NUMBER_OF_ELEMENTS) : tx_data_length;
            r_idx      <= '0;
            r_delay    <= delay_between_tx;
            r_div      <= (baud_divisor == '0) ? DIVISOR_WIDTH'(1) : baud_divisor;
            r_par_mode <= parity_mode;
            r_two_stop <= two_stop_bits;
            r_baud_cnt <= '0;
            r_state    <= S_START;
            r_line     <= 1'b0;
            r_ready    <= 1'b0;
`ifdef UART_TX_CRC8_TRAILER_EN
            r_crc       <= '0;
            r_crc_frame <= 1'b0;
`endif
          end
        end

        S_START: begin
          if (w_bit_end) begin
            // Element is fetched at the end of the start bit; parity is
            // precomputed here so the parity state only has to drive it.
            r_baud_cnt <= '0;
            r_shift    <= w_elem;
            r_par_bit  <= (^w_elem) ^ (r_par_mode == 2'b10);
            r_bit_cnt  <= '0;
            r_line     <= w_elem[0];
            r_state    <= S_DATA;
`ifdef UART_TX_CRC8_TRAILER_EN
            if (!r_crc_frame) r_crc <= crc8_step(r_crc, w_elem);
`endif
          end else begin
            r_baud_cnt <= r_baud_cnt + DIVISOR_WIDTH'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == BCW'(ELEMENT_WIDTH - 1)) begin
              if (w_par_en) begin
                r_state <= S_PARITY;
                r_line  <= r_par_bit;
              end else begin
                r_state    <= S_STOP;
                r_line     <= 1'b1;
                r_stop_cnt <= 1'b0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BCW'(1);
              r_shift   <= r_shift >> 1;
              r_line    <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + DIVISOR_WIDTH'(1);
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_state    <= S_STOP;
            r_line     <= 1'b1;
            r_stop_cnt <= 1'b0;
          end else begin
            r_baud_cnt <= r_baud_cnt + DIVISOR_WIDTH'(1);
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_two_stop && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else if (w_abort_now) begin
              r_state   <= S_IDLE;
              r_done    <= 1'b1;
              r_aborted <= 1'b1;
              r_ready   <= 1'b1;
            end else if (w_more) begin
`ifdef UART_TX_CRC8_TRAILER_EN
              if (w_last) r_crc_frame <= 1'b1;
              else        r_idx <= r_idx + LEN_W'(1);
`else
              r_idx <= r_idx + LEN_W'(1);
`endif
              if (r_delay == '0) begin
                r_state <= S_START;
                r_line  <= 1'b0;
              end else begin
                r_state   <= S_GAP;
                r_gap_cnt <= '0;
              end
            end else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + DIVISOR_WIDTH'(1);
          end
        end

        S_GAP: begin
          // An abort arriving between frames ends the message without
          // starting the next frame.
          if (w_abort_now) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
            r_ready   <= 1'b1;
          end else if (r_gap_cnt == r_delay - DELAY_WIDTH'(1)) begin
            r_state    <= S_START;
            r_line     <= 1'b0;
            r_baud_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + DELAY_WIDTH'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_line  <= 1'b1;
        end
      endcase
    end
  end

  assign tx_line    = r_line;
  assign tx_ready   = r_ready;
  assign tx_done    = r_done;
  assign tx_aborted = r_aborted;

endmodule

// File: tb/tb_multibyte_uart_tx_cfg.sv
// tb_multibyte_uart_tx_cfg
//   Directed bench for multibyte_uart_tx_cfg. Each message is captured cycle
//   by cycle (cycle 1 = first cycle after the accepting edge) and compared
//   against hand-written frame words {stop(s), parity, data, start}.
module tb_multibyte_uart_tx_cfg;

  localparam int EW  = 8;
  localparam int NE  = 256;
  localparam int DW  = 32;
  localparam int VW  = 16;
  localparam int LW  = $clog2(NE) + 1;
  localparam int CAP = 2704;

  logic                    clk;
  logic                    rst;
  logic                    tx_en;
  logic [NE-1:0][EW-1:0]   tx_data;
  logic [LW-1:0]           tx_data_length;
  logic [DW-1:0]           delay_between_tx;
  logic [VW-1:0]           baud_divisor;
  logic [1:0]              parity_mode;
  logic                    two_stop_bits;
  logic                    tx_abort;
  logic                    tx_line;
  logic                    tx_ready;
  logic                    tx_done;
  logic                    tx_aborted;

  logic cap_line  [0:CAP-1];
  logic cap_ready [0:CAP-1];
  logic cap_done  [0:CAP-1];
  logic cap_abt   [0:CAP-1];

  int n_checks;
  int n_errors;

  multibyte_uart_tx_cfg #(
    .ELEMENT_WIDTH      (EW),
    .NUMBER_OF_ELEMENTS (NE),
    .DELAY_WIDTH        (DW),
    .DIVISOR_WIDTH      (VW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tx_en            (tx_en),
    .tx_data          (tx_data),
    .tx_data_length   (tx_data_length),
    .delay_between_tx (delay_between_tx),
    .baud_divisor     (baud_divisor),
    .parity_mode      (parity_mode),
    .two_stop_bits    (two_stop_bits),
    .tx_abort         (tx_abort),
    .tx_line          (tx_line),
    .tx_ready         (tx_ready),
    .tx_done          (tx_done),
    .tx_aborted       (tx_aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge. Presents a request for one cycle, then records n
  // cycles of outputs. abort_at=0 asserts tx_abort together with tx_en.
  task automatic send(input int len, input int dly, input int div,
                      input logic [1:0] pm, input logic ts,
                      input int n, input int abort_at);
    tx_en            = 1'b1;
    tx_data_length   = LW'(len);
    delay_between_tx = DW'(dly);
    baud_divisor     = VW'(div);
    parity_mode      = pm;
    two_stop_bits    = ts;
    tx_abort         = (abort_at == 0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cap_line[k]  = tx_line;
      cap_ready[k] = tx_ready;
      cap_done[k]  = tx_done;
      cap_abt[k]   = tx_aborted;
      tx_en        = 1'b0;
      tx_abort     = (k == abort_at);
    end
    tx_abort = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int first,
                             input logic [15:0] bits, input int nbits, input int div);
    for (int b = 0; b < nbits; b++)
      for (int c = 0; c < div; c++)
        check(tag, int'(cap_line[first + b*div + c]), int'(bits[b]));
  endtask

  // sel: 0 line, 1 ready, 2 done
  function automatic int count_ones(input int sel, input int a, input int b);
    int s;
    s = 0;
    for (int k = a; k <= b; k++) begin
      case (sel)
        0:       s += int'(cap_line[k]);
        1:       s += int'(cap_ready[k]);
        default: s += int'(cap_done[k]);
      endcase
    end
    return s;
  endfunction

  function automatic int first_done(input int n);
    for (int k = 1; k <= n; k++)
      if (cap_done[k]) return k;
    return 0;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    tx_en = 1'b0;
    tx_abort = 1'b0;
    tx_data_length = '0;
    delay_between_tx = '0;
    baud_divisor = '0;
    parity_mode = 2'b00;
    two_stop_bits = 1'b0;
    for (int i = 0; i < NE; i++) tx_data[i] = EW'(i * 7 + 3);

    // Reset state and first cycle after release
    repeat (3) @(negedge clk);
    check("rst_line", int'(tx_line), 1);
    check("rst_ready", int'(tx_ready), 0);
    check("rst_done", int'(tx_done), 0);
    check("rst_aborted", int'(tx_aborted), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", int'(tx_ready), 1);

    // 1: 0xA5, div 4, no parity, 1 stop
    tx_data[0] = 8'hA5;
    send(1, 0, 4, 2'b00, 1'b0, 50, -1);
    check_frame("t1_bits", 1, 16'({1'b1, 8'hA5, 1'b0}), 10, 4);
    check("t1_ready_c1", int'(cap_ready[1]), 0);
    check("t1_ready_c40", int'(cap_ready[40]), 0);
    check("t1_done_c40", int'(cap_done[40]), 0);
    check("t1_done_c41", int'(cap_done[41]), 1);
    check("t1_ready_c41", int'(cap_ready[41]), 1);
    check("t1_abt_c41", int'(cap_abt[41]), 0);
    check("t1_done_c42", int'(cap_done[42]), 0);
    check("t1_idle_high", count_ones(0, 41, 50), 10);

    // 2: parity and stop variants
    send(1, 0, 4, 2'b01, 1'b0, 50, -1);
    check_frame("t2_even", 1, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 4);
    check("t2_even_done44", int'(cap_done[44]), 0);
    check("t2_even_done45", int'(cap_done[45]), 1);
    send(1, 0, 4, 2'b10, 1'b0, 50, -1);
    check_frame("t2_odd", 1, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, 4);
    check("t2_odd_done45", int'(cap_done[45]), 1);
    send(1, 0, 4, 2'b01, 1'b1, 55, -1);
    check_frame("t2_2stop", 1, 16'({2'b11, 1'b0, 8'hA5, 1'b0}), 12, 4);
    check("t2_2stop_done48", int'(cap_done[48]), 0);
    check("t2_2stop_done49", int'(cap_done[49]), 1);

    // 3: three frames, gap 10, div 2
    tx_data[0] = 8'h3C;
    tx_data[1] = 8'h81;
    tx_data[2] = 8'hFF;
    send(3, 10, 2, 2'b00, 1'b0, 90, -1);
    check_frame("t3_f0", 1, 16'({1'b1, 8'h3C, 1'b0}), 10, 2);
    check("t3_gap0", count_ones(0, 21, 30), 10);
    check_frame("t3_f1", 31, 16'({1'b1, 8'h81, 1'b0}), 10, 2);
    check("t3_gap1", count_ones(0, 51, 60), 10);
    check_frame("t3_f2", 61, 16'({1'b1, 8'hFF, 1'b0}), 10, 2);
    check("t3_ready_low", count_ones(1, 1, 80), 0);
    check("t3_done_at", first_done(90), 81);
    check("t3_done_cnt", count_ones(2, 1, 90), 1);

    // 4: abort pulsed during frame 2 of 4
    tx_data[0] = 8'h12;
    tx_data[1] = 8'h34;
    tx_data[2] = 8'h56;
    tx_data[3] = 8'h78;
    send(4, 0, 2, 2'b00, 1'b0, 70, 25);
    check_frame("t4_f0", 1, 16'({1'b1, 8'h12, 1'b0}), 10, 2);
    check_frame("t4_f1", 21, 16'({1'b1, 8'h34, 1'b0}), 10, 2);
    check("t4_done41", int'(cap_done[41]), 1);
    check("t4_abt41", int'(cap_abt[41]), 1);
    check("t4_no_f2", count_ones(0, 41, 70), 30);
    check("t4_done_cnt", count_ones(2, 1, 70), 1);

    // 7: abort with tx_en in IDLE still starts; divisor 0 acts as 1
    tx_data[0] = 8'h55;
    send(1, 0, 0, 2'b00, 1'b0, 20, 0);
    check_frame("t7_bits", 1, 16'({1'b1, 8'h55, 1'b0}), 10, 1);
    check("t7_done11", int'(cap_done[11]), 1);
    check("t7_abt11", int'(cap_abt[11]), 0);

    // 5: length 0 ignored, then reset mid-DATA
    send(0, 0, 4, 2'b00, 1'b0, 20, -1);
    check("t5_len0_line", count_ones(0, 1, 20), 20);
    check("t5_len0_ready", count_ones(1, 1, 20), 20);
    check("t5_len0_done", count_ones(2, 1, 20), 0);
    tx_data[0] = 8'h00;
    send(1, 0, 4, 2'b00, 1'b0, 10, -1);
    check("t5_in_data", int'(cap_line[10]), 0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_line", int'(tx_line), 1);
    check("t5_rst_ready", int'(tx_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rel_ready", int'(tx_ready), 1);
    send(0, 0, 4, 2'b00, 1'b0, 50, -1);
    check("t5_no_resume", count_ones(0, 1, 50), 50);
    check("t5_no_done", count_ones(2, 1, 50), 0);

    // 6: CRC trailer (0x01 -> 0x07) or single frame
    tx_data[0] = 8'h01;
    send(1, 3, 2, 2'b00, 1'b0, 60, -1);
    check_frame("t6_f0", 1, 16'({1'b1, 8'h01, 1'b0}), 10, 2);
`ifdef UART_TX_CRC8_TRAILER_EN
    check("t6_gap", count_ones(0, 21, 23), 3);
    check_frame("t6_crc", 24, 16'({1'b1, 8'h07, 1'b0}), 10, 2);
    check("t6_done_at", first_done(60), 44);
`else
    check("t6_done_at", first_done(60), 21);
    check("t6_single", count_ones(0, 21, 60), 40);
`endif

    // 8: length clamp, 300 -> 256 frames of 10 clocks at divisor 1
    send(300, 0, 1, 2'b00, 1'b0, 2600, -1);
    check("t8_ready_2560", int'(cap_ready[2560]), 0);
    check("t8_done_at", first_done(2600), 2561);
    check("t8_done_cnt", count_ones(2, 1, 2600), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
